// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Front-end fetch stage. Owns the PC, issues one-word fetches,
//            buffers responses in an in-order queue and launches the queue
//            head to the ROB. Static redirect on JAL (and optionally on
//            backward branches); rob_flush restarts fetch at flush_pc.
// Options  : IF_BRANCH_BTFN_EN - backward-taken/forward-not-taken branches.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter int IQ_SIZE  = 8,
  parameter int IQ_WIDTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        if_mem_req,
  output logic [31:0] if_mem_addr,
  input  logic        mem_if_valid,
  input  logic [31:0] mem_if_data,
  input  logic        rob_full,
  output logic        if_ins_launch_flag,
  output logic [31:0] if_ins,
  output logic [31:0] if_ins_pc,
  output logic        if_ins_pred_taken,
  input  logic        rob_flush,
  input  logic [31:0] flush_pc
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  localparam logic [6:0]          C_OP_JAL    = 7'b1101111;
  // Issue a new fetch only while the queue can still absorb its response.
  localparam logic [IQ_WIDTH:0]   C_ISSUE_MAX = (IQ_WIDTH+1)'(IQ_SIZE - 2);
  // After an enqueue, chain the next fetch only if there is room left.
  localparam logic [IQ_WIDTH:0]   C_CHAIN_MAX = (IQ_WIDTH+1)'(IQ_SIZE - 3);
  localparam logic [IQ_WIDTH:0]   C_CNT_ONE   = (IQ_WIDTH+1)'(1);
  localparam logic [IQ_WIDTH-1:0] C_PTR_ONE   = (IQ_WIDTH)'(1);

  state_t              r_state, w_state_nxt;
  logic [31:0]         r_pc, w_pc_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic [31:0]         r_mem_addr, w_mem_addr_nxt;
  logic                w_enq;
  logic                w_launch;
  logic [31:0]         w_next_pc;
  logic                w_pred;
  logic [31:0]         w_jal_imm;

  logic [31:0]         r_q_ins  [IQ_SIZE];
  logic [31:0]         r_q_pc   [IQ_SIZE];
  logic                r_q_pred [IQ_SIZE];
  logic [IQ_WIDTH-1:0] r_head, r_tail;
  logic [IQ_WIDTH:0]   r_count;

`ifdef IF_BRANCH_BTFN_EN
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  logic [31:0] w_br_imm;
  assign w_br_imm = {{20{mem_if_data[31]}}, mem_if_data[7], mem_if_data[30:25],
                     mem_if_data[11:8], 1'b0};
`else
  // rd/branch-immediate bits carry no meaning when branches are not predicted.
  logic w_unused_br_bits;
  assign w_unused_br_bits = ^mem_if_data[11:7];
`endif

  assign w_jal_imm = {{12{mem_if_data[31]}}, mem_if_data[19:12], mem_if_data[20],
                      mem_if_data[30:21], 1'b0};

  assign w_launch           = (r_count != '0) && !rob_full && !rob_flush && rdy;
  assign if_ins_launch_flag = w_launch;
  assign if_ins             = r_q_ins[r_head];
  assign if_ins_pc          = r_q_pc[r_head];
  assign if_ins_pred_taken  = r_q_pred[r_head];
  assign if_mem_req         = r_mem_req;
  assign if_mem_addr        = r_mem_addr;

  // Static next-PC prediction for the instruction currently returning.
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    w_pred    = 1'b0;
    if (mem_if_data[6:0] == C_OP_JAL) begin
      w_next_pc = r_pc + w_jal_imm;
      w_pred    = 1'b1;
    end
`ifdef IF_BRANCH_BTFN_EN
    else if ((mem_if_data[6:0] == C_OP_BRANCH) && w_br_imm[31]) begin
      w_next_pc = r_pc + w_br_imm;
      w_pred    = 1'b1;
    end
`endif
  end

  // Fetch FSM next-state, next request and next PC; flush outranks all else.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_enq          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rob_flush) begin
          w_pc_nxt = flush_pc;
        end else if (r_count <= C_ISSUE_MAX) begin
          w_state_nxt    = S_WAIT;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = r_pc;
        end
      end
      S_WAIT: begin
        if (rob_flush) begin
          w_pc_nxt      = flush_pc;
          w_mem_req_nxt = 1'b0;
          // A response landing with the flush is dropped and fully retired.
          w_state_nxt   = mem_if_valid ? S_IDLE : S_DISCARD;
        end else if (mem_if_valid) begin
          w_enq    = 1'b1;
          w_pc_nxt = w_next_pc;
          if (r_count <= C_CHAIN_MAX) begin
            w_mem_addr_nxt = w_next_pc;
          end else begin
            w_mem_req_nxt = 1'b0;
            w_state_nxt   = S_IDLE;
          end
        end
      end
      S_DISCARD: begin
        if (rob_flush) begin
          w_pc_nxt = flush_pc;
        end
        // The wrong-path response retires the outstanding request.
        if (mem_if_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  // FSM, PC and request registers; everything holds while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= 32'd0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'd0;
    end else if (rdy) begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
    end
  end

  // Queue entry storage; written at the tail on every accepted response.
  always_ff @(posedge clk) begin
    if (rdy && w_enq) begin
      r_q_ins[r_tail]  <= mem_if_data;
      r_q_pc[r_tail]   <= r_pc;
      r_q_pred[r_tail] <= w_pred;
    end
  end

  // Queue pointers and occupancy; a flush empties the queue outright.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      if (rob_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_enq) begin
          r_tail <= r_tail + C_PTR_ONE;
        end
        if (w_launch) begin
          r_head <= r_head + C_PTR_ONE;
        end
        case ({w_enq, w_launch})
          2'b10:   r_count <= r_count + C_CNT_ONE;
          2'b01:   r_count <= r_count - C_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
